// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cpu_seq_pkg : shared state, error and RV32I opcode encodings for the sequencer
// Revision    : 1.0
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'b00,
    ERR_ILLEGAL      = 2'b01,
    ERR_IMEM_TIMEOUT = 2'b10,
    ERR_DMEM_TIMEOUT = 2'b11
  } seq_err_t;

  localparam logic [6:0] c_OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] c_OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      c_OP_R_TYPE, c_OP_I_TYPE, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH,
      c_OP_JALR, c_OP_JAL, c_OP_AUIPC, c_OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cpu_sequencer_if : run control, memory handshakes and decoder hooks
// Revision         : 1.0
// -----------------------------------------------------------------------------
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic             ir_load;
  logic [6:0]       opcode;
  logic             dec_wEn;
  logic             dec_mem_wEn;
  logic             dec_wb_sel;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             rf_wEn;
  logic             pc_update;
  logic             halt;
  logic [1:0]       err_code;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, imem_ack, opcode, dec_wEn, dec_mem_wEn, dec_wb_sel, dmem_ack,
    output imem_req, ir_load, dmem_req, dmem_we, rf_wEn, pc_update, halt,
           err_code, state, instr_count
  );

  modport slave (
    output run, imem_ack, opcode, dec_wEn, dec_mem_wEn, dec_wb_sel, dmem_ack,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_wEn, pc_update, halt,
           err_code, state, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer_wait_timer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq_wait_timer : counts unacknowledged request cycles, flags the last allowed
// Revision       : 1.0
// -----------------------------------------------------------------------------
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);
  localparam int             c_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_W-1:0] c_LAST = c_W'(MEM_TIMEOUT - 1);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != c_LAST)) begin
      r_count <= r_count + c_W'(1);
    end
  end

  // High during the MEM_TIMEOUT-th request cycle; the caller lets an ack win.
  assign o_expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cpu_sequencer : multi-cycle RV32I fetch/decode/execute/mem/writeback control
// Revision      : 1.0
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  cpu_sequencer_if.master bus
);
  seq_state_t       r_state;
  seq_err_t         r_err;
  logic             r_halt;
  logic [CNT_W-1:0] r_instr_count;

  logic w_in_fetch;
  logic w_in_mem;
  logic w_in_wb;
  logic w_wait_clear;
  logic w_wait_en;
  logic w_expired;

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_mem   = (r_state == S_MEM);
  assign w_in_wb    = (r_state == S_WB);

  // FETCH and MEM are never adjacent, so any other state clears the timer.
  assign w_wait_clear = ~(w_in_fetch | w_in_mem);
  assign w_wait_en    = (w_in_fetch & ~bus.imem_ack) | (w_in_mem & ~bus.dmem_ack);

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (w_wait_clear),
    .i_count_en (w_wait_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_err         <= ERR_NONE;
      r_halt        <= 1'b0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_state <= S_DECODE;
          end else if (w_expired) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_err   <= ERR_IMEM_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (is_legal_opcode(bus.opcode)) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            if (bus.opcode == c_OP_SYSTEM) r_err <= ERR_NONE;
            else                           r_err <= ERR_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          if (bus.dec_wb_sel || !bus.dec_mem_wEn) r_state <= S_MEM;
          else                                    r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            r_state <= S_WB;
          end else if (w_expired) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_err   <= ERR_DMEM_TIMEOUT;
          end
        end
        S_WB: begin
          r_instr_count <= r_instr_count + CNT_W'(1);
          r_state       <= bus.run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req    = w_in_fetch;
  assign bus.ir_load     = w_in_fetch & bus.imem_ack;
  assign bus.dmem_req    = w_in_mem;
  assign bus.dmem_we     = w_in_mem & ~bus.dec_mem_wEn;
  assign bus.rf_wEn      = w_in_wb ? bus.dec_wEn : 1'b1;
  assign bus.pc_update   = w_in_wb;
  assign bus.halt        = r_halt;
  assign bus.err_code    = r_err;
  assign bus.state       = r_state;
  assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cpu_sequencer : directed scoreboard bench for cpu_sequencer
// Revision         : 1.0
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int c_TIMEOUT = 16;
  localparam int c_CNT_W   = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cpu_sequencer_if #(.CNT_W(c_CNT_W)) bus ();

  cpu_sequencer #(
    .MEM_TIMEOUT (c_TIMEOUT),
    .CNT_W       (c_CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_wEn;
    logic        pc_update;
    logic        halt;
    logic [1:0]  err;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          dmem_delay = 0;   // 0: ack tied high, <0: never ack
  int          mem_cyc    = 0;
  logic        imem_en    = 1'b1;
  logic [31:0] m_cnt      = 32'd0;
  logic        m_halt     = 1'b0;
  logic [1:0]  m_err      = 2'b00;
  string       tag        = "init";

  // outs = {imem_req, ir_load, dmem_req, dmem_we, rf_wEn, pc_update}
  task automatic push(input logic [2:0] st, input logic [5:0] outs);
    obs_t e;
    e.st        = st;
    e.imem_req  = outs[5];
    e.ir_load   = outs[4];
    e.dmem_req  = outs[3];
    e.dmem_we   = outs[2];
    e.rf_wEn    = outs[1];
    e.pc_update = outs[0];
    e.halt      = m_halt;
    e.err       = m_err;
    e.cnt       = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", tag, name, got, want);
    end
  endtask

  task automatic step();
    obs_t got;
    obs_t want;
    @(negedge clock);
    if (bus.dmem_req) begin
      bus.dmem_ack = (dmem_delay == 0) || ((dmem_delay > 0) && (mem_cyc >= dmem_delay));
      mem_cyc++;
    end else begin
      bus.dmem_ack = (dmem_delay == 0);
      mem_cyc      = 0;
    end
    bus.imem_ack = imem_en;
    #1;
    got.st        = bus.state;
    got.imem_req  = bus.imem_req;
    got.ir_load   = bus.ir_load;
    got.dmem_req  = bus.dmem_req;
    got.dmem_we   = bus.dmem_we;
    got.rf_wEn    = bus.rf_wEn;
    got.pc_update = bus.pc_update;
    got.halt      = bus.halt;
    got.err       = bus.err_code;
    got.cnt       = bus.instr_count;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected scoreboard entry, none queued", tag, got);
    end
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      n_checks++;
      assert (got === want) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
    end
  endtask

  task automatic alu_instr(input logic wen);
    bus.opcode      = c_OP_R_TYPE;
    bus.dec_wEn     = wen;
    bus.dec_mem_wEn = 1'b1;
    bus.dec_wb_sel  = 1'b0;
    push(3'd1, 6'b110010);
    push(3'd2, 6'b000010);
    push(3'd3, 6'b000010);
    push(3'd5, {4'b0000, wen, 1'b1});
    m_cnt = m_cnt + 32'd1;
    repeat (4) step();
  endtask

  // delay >= 0: ack in MEM cycle delay+1; delay < 0: no ack, expect timeout
  task automatic mem_instr(input logic [6:0] op, input logic wb_sel, input logic mem_wen,
                           input logic wen, input int delay);
    bus.opcode      = op;
    bus.dec_wEn     = wen;
    bus.dec_mem_wEn = mem_wen;
    bus.dec_wb_sel  = wb_sel;
    dmem_delay      = delay;
    push(3'd1, 6'b110010);
    push(3'd2, 6'b000010);
    push(3'd3, 6'b000010);
    if (delay >= 0) begin
      repeat (delay + 1) push(3'd4, {3'b001, ~mem_wen, 2'b10});
      push(3'd5, {4'b0000, wen, 1'b1});
      m_cnt = m_cnt + 32'd1;
      repeat (delay + 5) step();
    end else begin
      repeat (c_TIMEOUT) push(3'd4, {3'b001, ~mem_wen, 2'b10});
      m_halt = 1'b1;
      m_err  = 2'b11;
      repeat (3) push(3'd6, 6'b000010);
      repeat (c_TIMEOUT + 6) step();
    end
  endtask

  task automatic halt_instr(input logic [6:0] op, input logic [1:0] err);
    bus.opcode = op;
    push(3'd1, 6'b110010);
    push(3'd2, 6'b000010);
    m_halt = 1'b1;
    m_err  = err;
    repeat (3) push(3'd6, 6'b000010);
    repeat (5) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_cnt   = 32'd0;
    m_halt  = 1'b0;
    m_err   = 2'b00;
    push(3'd0, 6'b000010);
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.run         = 1'b0;
    bus.imem_ack    = 1'b1;
    bus.dmem_ack    = 1'b1;
    bus.opcode      = c_OP_R_TYPE;
    bus.dec_wEn     = 1'b1;
    bus.dec_mem_wEn = 1'b1;
    bus.dec_wb_sel  = 1'b0;

    tag = "reset";
    push(3'd0, 6'b000010);
    step();
    reset_n = 1'b1;

    tag = "idle_no_run";
    push(3'd0, 6'b000010);
    step();

    bus.run = 1'b1;
    tag = "alu_x3";
    repeat (3) alu_instr(1'b0);

    tag = "load_wait3";
    mem_instr(c_OP_LOAD, 1'b1, 1'b1, 1'b0, 3);

    tag = "store";
    mem_instr(c_OP_STORE, 1'b0, 1'b0, 1'b1, 0);

    tag = "run_drop";
    bus.opcode      = c_OP_I_TYPE;
    bus.dec_wEn     = 1'b0;
    bus.dec_mem_wEn = 1'b1;
    bus.dec_wb_sel  = 1'b0;
    push(3'd1, 6'b110010);
    push(3'd2, 6'b000010);
    push(3'd3, 6'b000010);
    push(3'd5, 6'b000001);
    m_cnt = m_cnt + 32'd1;
    push(3'd0, 6'b000010);
    push(3'd0, 6'b000010);
    step();
    step();
    bus.run = 1'b0;
    repeat (4) step();

    tag = "reset_mid_mem";
    bus.run         = 1'b1;
    bus.opcode      = c_OP_LOAD;
    bus.dec_wb_sel  = 1'b1;
    dmem_delay      = -1;
    push(3'd1, 6'b110010);
    push(3'd2, 6'b000010);
    push(3'd3, 6'b000010);
    push(3'd4, 6'b001010);
    push(3'd4, 6'b001010);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check32("dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    check32("instr_count", bus.instr_count, 32'd0);
    check32("state", {29'd0, bus.state}, 32'd0);
    m_cnt = 32'd0;
    push(3'd0, 6'b000010);
    step();
    reset_n = 1'b1;

    tag = "mem_ack_on_16";
    mem_instr(c_OP_LOAD, 1'b1, 1'b1, 1'b0, c_TIMEOUT - 1);

    tag = "mem_timeout";
    mem_instr(c_OP_LOAD, 1'b1, 1'b1, 1'b0, -1);
    do_reset();

    tag = "illegal";
    halt_instr(7'b0000000, 2'b01);
    do_reset();

    tag = "system";
    halt_instr(c_OP_SYSTEM, 2'b00);
    do_reset();

    tag = "imem_timeout";
    imem_en = 1'b0;
    repeat (c_TIMEOUT) push(3'd1, 6'b100010);
    m_halt = 1'b1;
    m_err  = 2'b10;
    repeat (2) push(3'd6, 6'b000010);
    repeat (c_TIMEOUT + 2) step();

    tag = "scoreboard_drained";
    check32("queue_size", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
